kissp_ctrl: RTL
===============

KISSP_CTRL -- requirements
Module: kissp_ctrl

Interface
REQ-001 Parameters: none.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 start  in  1  begin execution from IDLE; ignored in all other states.
REQ-005 halted  out  1  high while in HALT.
REQ-006 retire  out  1  one-cycle pulse in the WB cycle of every completed instruction, HALT included.
REQ-007 pc  out  32  current program counter, word address.
REQ-008 mem_w  out  1; mem_addr  out  32; mem_w_v  out  32; mem_r_v  in  32: memory port. Reads are combinational; writes occur on falling clk.
REQ-009 reg_w  out  1; reg_dst, reg_src1, reg_src2  out  5; reg_w_v  out  32: register-file port. Writes occur on falling clk.
REQ-010 src1_v, src2_v, src3_v  in  32  combinational register reads of reg_src1, reg_src2 and reg_dst; register 0 reads as 0.
REQ-011 alu_op  out  1 (1 = add, 0 = sub); alu_out  in  32 = src1 ± src2 + src3.

Function
REQ-012 Instruction fields: cls = ir[31:30], aop = ir[29], imm = ir[29:15] (signed 15-bit), dst = ir[14:10], src1 = ir[9:5], src2 = ir[4:0].
REQ-013 FSM states: IDLE, FETCH, DECODE, EXEC, WB, HALT. Transitions:
- IDLE -> FETCH on start.
- FETCH -> DECODE -> EXEC -> WB, unconditionally.
- WB -> FETCH, or WB -> HALT for a halt instruction.
- HALT holds until rst.
REQ-014 FETCH: mem_addr = pc; ir latches mem_r_v at the end of the cycle.
REQ-015 DECODE: reg_src1, reg_src2 and reg_dst are driven from ir; A, B and C latch src1_v, src2_v and src3_v. These selects hold through EXEC and WB.
REQ-016 EXEC: alu_op = aop for cls 00, otherwise 0; R latches alu_out.
REQ-017 cls 00 (ALU): in WB, reg_w = 1 and reg_w_v = R. Arithmetic wraps modulo 2^32.
REQ-018 cls 01 (LOAD): in WB, mem_addr = A, reg_w = 1 and reg_w_v = mem_r_v.
REQ-019 cls 10 (STORE): in WB, mem_addr = A, mem_w = 1 and mem_w_v = B.
REQ-020 cls 11 with imm != 0 (BRANCH): in WB, pc <= pc + sext(imm) if A == 0, else pc + 1. The offset is relative to the branch's own address; addition wraps modulo 2^32.
REQ-021 cls 11 with imm == 0 (HALT): WB -> HALT; pc is unchanged and no write strobe is asserted.
REQ-022 Non-branch, non-halt instructions: pc <= pc + 1 at the end of WB; 0xFFFFFFFF wraps to 0.
REQ-023 reg_w and mem_w are high only in WB and never together; reg_w asserts even when dst = 0.
REQ-024 Outside FETCH and LOAD/STORE WB, mem_addr = pc.
REQ-025 mem_addr is not range-checked; software keeps addresses within 0..4096.
REQ-026 Latency: exactly 4 cycles per instruction, FETCH through WB; no stalls.

Reset
REQ-027 When rst is sampled high, from that edge:
- state = IDLE, pc = 0, ir/A/B/C/R = 0;
- halted, retire, reg_w, mem_w = 0; alu_op = 0.
REQ-028 rst overrides start and all transitions, including in HALT.
REQ-029 rst sampled at the edge ending EXEC suppresses that instruction's write-back. A WB cycle already entered completes its falling-edge write.

Verification
REQ-030 ALU add: mem[0] = {00,1,…,dst 3, src1 1, src2 2}, r1 = 5, r2 = 7, r3 = 1, start -> WB on the 4th cycle after FETCH entry: reg_w = 1, reg_w_v = 13; then pc = 1, retire pulses once.
REQ-031 ALU sub: same fields with aop = 0, r3 = 0 -> reg_w_v = 0xFFFFFFFE.
REQ-032 STORE r1 = 100, r2 = 0xDEAD; then LOAD dst 4, src1 1 -> mem_w with mem_addr = 100 and mem_w_v = 0xDEAD; then r4 = 0xDEAD; mem_w and reg_w never overlap.
REQ-033 BRANCH at pc = 5, imm = -2: with r1 = 0 -> pc = 3; with r1 = 1 -> pc = 6; no write strobes.
REQ-034 HALT at pc = 2 -> halted = 1 after WB, pc stays 2; later start pulses produce no FETCH or strobes; rst -> IDLE, pc = 0.
REQ-035 rst asserted during EXEC of an ALU instruction -> no reg_w pulse; state IDLE, pc = 0 the next cycle.

Source files
------------

// File: rtl/kissp_ctrl.sv
// kissp_ctrl: multi-cycle controller for a small load/store machine.
// Each instruction takes FETCH, DECODE, EXEC and WB; the memory and register file are external.
module kissp_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        halted,
    output logic        retire,
    output logic [31:0] pc,
    output logic        mem_w,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_w_v,
    input  logic [31:0] mem_r_v,
    output logic        reg_w,
    output logic [4:0]  reg_dst,
    output logic [4:0]  reg_src1,
    output logic [4:0]  reg_src2,
    output logic [31:0] reg_w_v,
    input  logic [31:0] src1_v,
    input  logic [31:0] src2_v,
    input  logic [31:0] src3_v,
    output logic        alu_op,
    input  logic [31:0] alu_out
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StExec,
        StWb,
        StHalt
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] c_q, c_d;
    logic [31:0] r_q, r_d;

    logic [1:0]  cls;
    logic        aop;
    logic [14:0] imm;
    logic [31:0] imm_sext;
    logic        is_alu, is_load, is_store, is_ctl, is_halt, is_branch;
    logic        in_wb;

    assign cls       = ir_q[31:30];
    assign aop       = ir_q[29];
    assign imm       = ir_q[29:15];
    assign imm_sext  = {{17{imm[14]}}, imm};
    assign is_alu    = (cls == 2'b00);
    assign is_load   = (cls == 2'b01);
    assign is_store  = (cls == 2'b10);
    assign is_ctl    = (cls == 2'b11);
    assign is_halt   = is_ctl && (imm == 15'd0);
    assign is_branch = is_ctl && (imm != 15'd0);
    assign in_wb     = (state_q == StWb);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            pc_q    <= 32'd0;
            ir_q    <= 32'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            c_q     <= 32'd0;
            r_q     <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            r_q     <= r_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        r_d     = r_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                ir_d    = mem_r_v;
                state_d = StDecode;
            end
            StDecode: begin
                a_d     = src1_v;
                b_d     = src2_v;
                c_d     = src3_v;
                state_d = StExec;
            end
            StExec: begin
                r_d     = alu_out;
                state_d = StWb;
            end
            StWb: begin
                if (is_halt) begin
                    state_d = StHalt;
                end else begin
                    state_d = StFetch;
                    // Branch offset is relative to the branch's own address.
                    if (is_branch && (a_q == 32'd0)) begin
                        pc_d = pc_q + imm_sext;
                    end else begin
                        pc_d = pc_q + 32'd1;
                    end
                end
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        pc       = pc_q;
        halted   = (state_q == StHalt);
        retire   = in_wb;
        reg_src1 = ir_q[9:5];
        reg_src2 = ir_q[4:0];
        reg_dst  = ir_q[14:10];
        alu_op   = (state_q == StExec) && is_alu && aop;
        mem_addr = pc_q;
        if (in_wb && (is_load || is_store)) begin
            mem_addr = a_q;
        end
        mem_w    = in_wb && is_store;
        mem_w_v  = b_q;
        reg_w    = in_wb && (is_alu || is_load);
        reg_w_v  = is_load ? mem_r_v : r_q;
    end

endmodule
